// File: rtl/cps_angle_scheduler.sv
// Carrier phase-shift scheduler for a three-module CSPWM leg.
// Computes the carrier initial angles for modules A/B/C, spreading the active
// modules evenly over one carrier period and rotating slot ownership. Each new
// angle set is built in shadow registers and committed atomically on a Syn
// rising edge.
`timescale 1ns/1ps

module cps_angle_scheduler (
    input  logic        clk_20M,
    input  logic        reset_n,
    input  logic        start,
    input  logic        Syn,
    input  logic [15:0] Frequency,
    input  logic [2:0]  bypass,
    input  logic [7:0]  rot_periods,
    output logic [15:0] Angle_initialA,
    output logic [15:0] Angle_initialB,
    output logic [15:0] Angle_initialC,
    output logic [1:0]  active_cnt,
    output logic        update,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_DIVIDE,
        S_ASSIGN,
        S_WAIT_SYN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_syn_d;
    logic        r_start_d;
    logic        w_syn_edge;
    logic        w_start_rise;
    logic        w_change;
    logic        w_rot_due;
    logic        w_trigger;
    logic        w_commit;

    logic [15:0] r_freq_lat;
    logic [2:0]  r_byp_lat;
    logic [1:0]  r_n;
    logic [1:0]  w_n_new;

    logic        r_pending;
    logic [7:0]  r_rot_cnt;
    logic [1:0]  r_rot;
    logic [1:0]  r_rot_lat;

    logic [16:0] r_quo;
    logic [1:0]  r_rem;
    logic [4:0]  r_div_cnt;
    logic [2:0]  w_rem_sh;
    logic [1:0]  w_rem_sub;
    logic        w_ge;

    logic [1:0]  r_asg_idx;
    logic [16:0] r_acc;
    logic [1:0]  r_slot;
    logic [16:0] w_step;
    logic [16:0] w_acc_init;
    logic [16:0] w_acc_cur;
    logic [1:0]  w_slot_cur;
    logic        w_act;
    logic        w_slot_wrap;
    logic [15:0] w_val;

    logic [15:0] r_sh_a;
    logic [15:0] r_sh_b;
    logic [15:0] r_sh_c;
    logic [1:0]  r_sh_n;
    logic        r_sh_fault;

    // Trigger sources: start edge, input change against the latched copy, rotation.
    assign w_syn_edge   = Syn & ~r_syn_d;
    assign w_start_rise = start & ~r_start_d;
    // LATCH is capturing the live inputs this cycle, so a mismatch there is not a change.
    assign w_change     = start && (r_state != S_LATCH) &&
                          ((bypass != r_byp_lat) || (Frequency != r_freq_lat));
    assign w_rot_due    = start && (rot_periods != 8'd0) && w_syn_edge &&
                          (({1'b0, r_rot_cnt} + 9'd1) >= {1'b0, rot_periods});
    assign w_trigger    = w_start_rise | w_change | w_rot_due;

    // Number of active modules is the popcount of the inverted bypass mask.
    assign w_n_new = {1'b0, ~bypass[0]} + {1'b0, ~bypass[1]} + {1'b0, ~bypass[2]};

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_sh  = {r_rem, r_quo[16]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_n});
    assign w_rem_sub = w_rem_sh[1:0] - r_n;

    // Slot arithmetic for the module handled in the current ASSIGN cycle.
    always_comb begin
        w_step      = (r_n == 2'd0) ? 17'd0 : r_quo;
        w_acc_init  = 17'd0;
        w_acc_cur   = r_acc;
        w_slot_cur  = r_slot;
        w_act       = 1'b0;
        w_slot_wrap = 1'b0;
        w_val       = 16'd0;
        // Starting offset r*step, with r at most 2, built from additions only.
        case (r_rot_lat)
            2'd1:    w_acc_init = w_step;
            2'd2:    w_acc_init = w_step + w_step;
            default: w_acc_init = 17'd0;
        endcase
        if (r_asg_idx == 2'd0) begin
            w_acc_cur  = w_acc_init;
            w_slot_cur = r_rot_lat;
        end
        case (r_asg_idx)
            2'd0:    w_act = ~r_byp_lat[0];
            2'd1:    w_act = ~r_byp_lat[1];
            default: w_act = ~r_byp_lat[2];
        endcase
        w_slot_wrap = (({1'b0, w_slot_cur} + 3'd1) >= {1'b0, r_n});
        if (w_act) begin
            w_val = w_acc_cur[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, busy flag and commit strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger || r_pending) begin
                    w_state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                busy        = 1'b1;
                w_state_nxt = S_DIVIDE;
            end
            S_DIVIDE: begin
                busy = 1'b1;
                if (r_div_cnt == 5'd16) begin
                    w_state_nxt = S_ASSIGN;
                end
            end
            S_ASSIGN: begin
                busy = 1'b1;
                if (r_asg_idx == 2'd2) begin
                    w_state_nxt = S_WAIT_SYN;
                end
            end
            S_WAIT_SYN: begin
                if (w_syn_edge) begin
                    w_commit    = 1'b1;
                    w_state_nxt = (w_trigger || r_pending) ? S_LATCH : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!start) begin
            w_state_nxt = S_IDLE;
            w_commit    = 1'b0;
        end
    end

    // Delayed copies of Syn and start for edge detection.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_syn_d   <= 1'b0;
            r_start_d <= 1'b0;
        end else begin
            r_syn_d   <= Syn;
            r_start_d <= start;
        end
    end

    // Pending request: remembers triggers that arrive while a set is in flight.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (!start) begin
            r_pending <= 1'b0;
        end else if (w_state_nxt == S_LATCH) begin
            r_pending <= 1'b0;
        end else if (w_trigger && (r_state != S_IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    // Rotation: count Syn edges and advance the slot offset r modulo n.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_rot_cnt <= 8'd0;
            r_rot     <= 2'd0;
        end else if (!start) begin
            r_rot_cnt <= 8'd0;
            r_rot     <= 2'd0;
        end else begin
            if (rot_periods == 8'd0) begin
                r_rot_cnt <= 8'd0;
            end else if (w_syn_edge) begin
                r_rot_cnt <= w_rot_due ? 8'd0 : r_rot_cnt + 8'd1;
            end
            if ((r_state == S_LATCH) && (w_n_new != r_n)) begin
                r_rot <= 2'd0;
            end else if (w_rot_due) begin
                r_rot <= (({1'b0, r_rot} + 3'd1) >= {1'b0, r_n}) ? 2'd0 : r_rot + 2'd1;
            end
        end
    end

    // Shadow datapath: latch inputs, divide P by n, then build the three angles.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            r_freq_lat <= 16'd0;
            r_byp_lat  <= 3'd0;
            r_n        <= 2'd0;
            r_rot_lat  <= 2'd0;
            r_quo      <= 17'd0;
            r_rem      <= 2'd0;
            r_div_cnt  <= 5'd0;
            r_asg_idx  <= 2'd0;
            r_acc      <= 17'd0;
            r_slot     <= 2'd0;
            r_sh_a     <= 16'd0;
            r_sh_b     <= 16'd0;
            r_sh_c     <= 16'd0;
            r_sh_n     <= 2'd0;
            r_sh_fault <= 1'b0;
        end else begin
            case (r_state)
                S_LATCH: begin
                    r_freq_lat <= Frequency;
                    r_byp_lat  <= bypass;
                    r_n        <= w_n_new;
                    r_rot_lat  <= (w_n_new != r_n) ? 2'd0 : r_rot;
                    r_quo      <= {Frequency, 1'b0};
                    r_rem      <= 2'd0;
                    r_div_cnt  <= 5'd0;
                    r_asg_idx  <= 2'd0;
                end
                S_DIVIDE: begin
                    r_rem     <= w_ge ? w_rem_sub : w_rem_sh[1:0];
                    r_quo     <= {r_quo[15:0], w_ge};
                    r_div_cnt <= r_div_cnt + 5'd1;
                end
                S_ASSIGN: begin
                    r_asg_idx <= r_asg_idx + 2'd1;
                    if (r_asg_idx == 2'd0) begin
                        r_sh_n     <= r_n;
                        r_sh_fault <= (r_n == 2'd0) || (r_freq_lat == 16'd0);
                    end
                    case (r_asg_idx)
                        2'd0:    r_sh_a <= w_val;
                        2'd1:    r_sh_b <= w_val;
                        default: r_sh_c <= w_val;
                    endcase
                    if (!w_act) begin
                        r_acc  <= w_acc_cur;
                        r_slot <= w_slot_cur;
                    end else if (w_slot_wrap) begin
                        r_acc  <= 17'd0;
                        r_slot <= 2'd0;
                    end else begin
                        r_acc  <= w_acc_cur + w_step;
                        r_slot <= w_slot_cur + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Commit: copy the shadow set to the outputs in one step and pulse update.
    always_ff @(posedge clk_20M or negedge reset_n) begin
        if (!reset_n) begin
            Angle_initialA <= 16'd0;
            Angle_initialB <= 16'd0;
            Angle_initialC <= 16'd0;
            active_cnt     <= 2'd0;
            fault          <= 1'b0;
            update         <= 1'b0;
        end else begin
            update <= w_commit;
            if (w_commit) begin
                Angle_initialA <= r_sh_a;
                Angle_initialB <= r_sh_b;
                Angle_initialC <= r_sh_c;
                active_cnt     <= r_sh_n;
                fault          <= r_sh_fault;
            end
        end
    end

endmodule

// File: tb/tb_cps_angle_scheduler.sv
// Testbench for cps_angle_scheduler: directed steps, expected angle sets
// queued when stimulus is applied and checked when update pulses.
`timescale 1ns/1ps

module tb_cps_angle_scheduler;

    logic        clk_20M = 1'b0;
    logic        reset_n;
    logic        start;
    logic        Syn;
    logic [15:0] Frequency;
    logic [2:0]  bypass;
    logic [7:0]  rot_periods;
    logic [15:0] Angle_initialA;
    logic [15:0] Angle_initialB;
    logic [15:0] Angle_initialC;
    logic [1:0]  active_cnt;
    logic        update;
    logic        busy;
    logic        fault;

    int tests    = 0;
    int fails    = 0;
    int upd_cnt  = 0;
    int busy_run = 0;
    int last_run = 0;

    // Packed expectation: {A, B, C, active_cnt, fault}
    logic [50:0] exp_q[$];

    always #25 clk_20M = ~clk_20M;

    cps_angle_scheduler dut (
        .clk_20M        (clk_20M),
        .reset_n        (reset_n),
        .start          (start),
        .Syn            (Syn),
        .Frequency      (Frequency),
        .bypass         (bypass),
        .rot_periods    (rot_periods),
        .Angle_initialA (Angle_initialA),
        .Angle_initialB (Angle_initialB),
        .Angle_initialC (Angle_initialC),
        .active_cnt     (active_cnt),
        .update         (update),
        .busy           (busy),
        .fault          (fault)
    );

    // Reference: evenly spaced slots, active module k gets ((k+r) mod n) * floor(2F/n).
    function automatic logic [50:0] model(input int freq, input logic [2:0] byp, input int r);
        int p;
        int n;
        int step;
        int k;
        int ang[3];
        logic flt;
        p = 2 * freq;
        n = 0;
        for (int i = 0; i < 3; i++) if (!byp[i]) n++;
        step = (n == 0) ? 0 : p / n;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            if (byp[i]) begin
                ang[i] = 0;
            end else begin
                ang[i] = ((k + r) % n) * step;
                k++;
            end
        end
        flt = (n == 0) || (freq == 0);
        return {16'(ang[0]), 16'(ang[1]), 16'(ang[2]), 2'(n), flt};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_20M);
        #1;
    endtask

    task automatic syn_edge();
        Syn = 1'b1;
        tick(1);
        Syn = 1'b0;
        tick(1);
    endtask

    // Output monitor: busy run length and scoreboard check on every update.
    always @(negedge clk_20M) begin
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
        if (reset_n && update) begin
            upd_cnt++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_update: observed A=%0d B=%0d C=%0d expected no update",
                       Angle_initialA, Angle_initialB, Angle_initialC);
            end
            if (exp_q.size() != 0) begin
                chk("commit_set",
                    64'({Angle_initialA, Angle_initialB, Angle_initialC, active_cnt, fault}),
                    64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        Syn         = 1'b0;
        Frequency   = 16'd0;
        bypass      = 3'b000;
        rot_periods = 8'd0;
        tick(3);
        chk("rst_angles", 64'({Angle_initialA, Angle_initialB, Angle_initialC}), 64'd0);
        chk("rst_flags", 64'({active_cnt, update, busy, fault}), 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Full spread, first commit and exact commit timing
        Frequency = 16'd1000;
        last_run  = 0;
        start     = 1'b1;
        exp_q.push_back(model(1000, 3'b000, 0));
        tick(25);
        chk("busy_len_first", 64'(last_run), 64'd21);
        chk("busy_low_ready", 64'(busy), 64'd0);
        chk("no_early_update", 64'(upd_cnt), 64'd0);
        Syn = 1'b1;
        chk("update_before_commit", 64'(update), 64'd0);
        tick(1);
        chk("update_at_commit", 64'(update), 64'd1);
        chk("angleC_at_commit", 64'(Angle_initialC), 64'd1332);
        Syn = 1'b0;
        tick(1);
        chk("update_one_cycle", 64'(update), 64'd0);
        chk("upd_cnt_1", 64'(upd_cnt), 64'd1);

        // Bypass B; Syn during busy must not commit
        bypass = 3'b010;
        exp_q.push_back(model(1000, 3'b010, 0));
        tick(3);
        chk("busy_mid_compute", 64'(busy), 64'd1);
        syn_edge();
        chk("no_update_busy", 64'(upd_cnt), 64'd1);
        tick(25);
        syn_edge();
        chk("upd_cnt_2", 64'(upd_cnt), 64'd2);

        // Back to three modules, then rotation every 2 Syn edges
        bypass = 3'b000;
        exp_q.push_back(model(1000, 3'b000, 0));
        tick(25);
        syn_edge();
        rot_periods = 8'd2;
        tick(2);
        syn_edge();
        chk("no_rot_first_syn", 64'(busy), 64'd0);
        exp_q.push_back(model(1000, 3'b000, 1));
        syn_edge();
        tick(25);
        syn_edge();
        chk("upd_cnt_rot1", 64'(upd_cnt), 64'd4);
        exp_q.push_back(model(1000, 3'b000, 2));
        syn_edge();
        tick(25);
        syn_edge();
        chk("upd_cnt_rot2", 64'(upd_cnt), 64'd5);
        rot_periods = 8'd0;
        tick(2);

        // Degenerate sets: all bypassed, then zero period
        bypass = 3'b111;
        exp_q.push_back(model(1000, 3'b111, 0));
        tick(25);
        syn_edge();
        chk("fault_all_bypass", 64'(fault), 64'd1);
        bypass = 3'b000;
        exp_q.push_back(model(1000, 3'b000, 0));
        tick(25);
        syn_edge();
        // Zero period: active_cnt still reports the popcount of active modules
        Frequency = 16'd0;
        exp_q.push_back(model(0, 3'b000, 0));
        tick(25);
        syn_edge();
        Frequency = 16'd1000;
        exp_q.push_back(model(1000, 3'b000, 0));
        tick(25);
        syn_edge();
        chk("fault_cleared", 64'(fault), 64'd0);
        chk("upd_cnt_deg", 64'(upd_cnt), 64'd9);

        // start low holds outputs; Frequency change mid-divide yields two commits
        start = 1'b0;
        tick(3);
        chk("hold_angleB", 64'(Angle_initialB), 64'd666);
        chk("idle_when_stopped", 64'(busy), 64'd0);
        start = 1'b1;
        exp_q.push_back(model(1000, 3'b000, 0));
        exp_q.push_back(model(500, 3'b000, 0));
        tick(5);
        Frequency = 16'd500;
        tick(25);
        syn_edge();
        tick(25);
        syn_edge();
        chk("upd_cnt_pending", 64'(upd_cnt), 64'd11);

        // Reset in the middle of a divide
        Frequency = 16'd1000;
        tick(5);
        chk("busy_before_reset", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_angles", 64'({Angle_initialA, Angle_initialB, Angle_initialC}), 64'd0);
        chk("async_rst_flags", 64'({active_cnt, update, busy, fault}), 64'd0);
        start = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        last_run = 0;
        start    = 1'b1;
        exp_q.push_back(model(1000, 3'b000, 0));
        tick(25);
        chk("busy_len_restart", 64'(last_run), 64'd21);
        syn_edge();
        chk("upd_cnt_final", 64'(upd_cnt), 64'd12);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
